// File: rtl/core_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : core_mem_arbiter
//  Description : Registered, handshaked arbiter placing N core memory
//                requests onto one device port. Round-robin or fixed
//                priority, optional burst lock, response timeout and
//                per-core ack/err routing.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_mem_arbiter #(
    parameter int NUM_CORES      = 16,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int ARB_MODE       = 0,
    parameter int MAX_BURST      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_CORES-1:0]          core_req,
    input  logic [NUM_CORES-1:0]          core_we,
    input  logic [NUM_CORES-1:0]          core_lock,
    input  logic [NUM_CORES*ADDR_W-1:0]   core_addr,
    input  logic [NUM_CORES*DATA_W-1:0]   core_wdata,
    output logic [NUM_CORES-1:0]          core_ack,
    output logic [NUM_CORES-1:0]          core_err,
    output logic [DATA_W-1:0]             core_rdata,
    output logic [ADDR_W-1:0]             device_addr,
    output logic                          device_read_en,
    output logic                          device_write_en,
    output logic [DATA_W-1:0]             device_data_out,
    input  logic [DATA_W-1:0]             device_data_in,
    input  logic                          device_ready,
    output logic [$clog2(NUM_CORES)-1:0]  device_core_id,
    output logic                          busy
);

    localparam int c_ID_W = $clog2(NUM_CORES);
    localparam int c_BC_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int c_WC_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [c_BC_W-1:0]    c_BURST_LAST = c_BC_W'(MAX_BURST - 1);
    localparam logic [c_WC_W-1:0]    c_WAIT_LAST  = c_WC_W'(TIMEOUT_CYCLES - 1);
    localparam logic [NUM_CORES-1:0] c_ONE        = NUM_CORES'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic [c_ID_W-1:0]      r_id;
    logic [c_ID_W-1:0]      r_rr_ptr;
    logic                   r_lock_valid;
    logic [c_BC_W-1:0]      r_burst_cnt;
    logic [c_WC_W-1:0]      r_wait_cnt;

    logic [NUM_CORES-1:0]   r_ack;
    logic [NUM_CORES-1:0]   r_err;
    logic [DATA_W-1:0]      r_rdata;
    logic [ADDR_W-1:0]      r_addr;
    logic [DATA_W-1:0]      r_wdata;
    logic                   r_rd_en;
    logic                   r_wr_en;

    logic                   w_lock_hit;
    logic                   w_win_valid;
    logic [c_ID_W-1:0]      w_win_id;
    logic                   w_win_we;
    logic [ADDR_W-1:0]      w_win_addr;
    logic [DATA_W-1:0]      w_win_data;
    logic                   w_timeout;
    logic [NUM_CORES-1:0]   w_id_onehot;

    // A held lock only counts while the locking core still requests
    assign w_lock_hit  = r_lock_valid && core_req[r_id];
    assign w_timeout   = (TIMEOUT_CYCLES != 0) && (r_wait_cnt == c_WAIT_LAST);
    assign w_id_onehot = c_ONE << r_id;

    // Winner selection: lock holder first, then round-robin or lowest index
    always_comb begin
        w_win_valid = 1'b0;
        w_win_id    = '0;
        if (w_lock_hit) begin
            w_win_valid = 1'b1;
            w_win_id    = r_id;
        end else if (ARB_MODE == 0) begin
            for (int i = 1; i <= NUM_CORES; i++) begin
                if (!w_win_valid && core_req[c_ID_W'((int'(r_rr_ptr) + i) % NUM_CORES)]) begin
                    w_win_valid = 1'b1;
                    w_win_id    = c_ID_W'((int'(r_rr_ptr) + i) % NUM_CORES);
                end
            end
        end else begin
            for (int i = NUM_CORES - 1; i >= 0; i--) begin
                if (core_req[i]) begin
                    w_win_valid = 1'b1;
                    w_win_id    = c_ID_W'(i);
                end
            end
        end
    end

    // Fetch the winning core's transaction fields
    always_comb begin
        w_win_we   = 1'b0;
        w_win_addr = '0;
        w_win_data = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (w_win_id == c_ID_W'(i)) begin
                w_win_we   = core_we[i];
                w_win_addr = core_addr[i*ADDR_W +: ADDR_W];
                w_win_data = core_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Next-state decode
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            S_IDLE:  if (w_win_valid) w_next_state = S_ISSUE;
            S_ISSUE: w_next_state = S_WAIT;
            S_WAIT:  if (device_ready || w_timeout) w_next_state = S_RESP;
            S_RESP:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // Transaction datapath, strobes, acks and burst-lock bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            r_id         <= '0;
            r_rr_ptr     <= c_ID_W'(NUM_CORES - 1);
            r_lock_valid <= 1'b0;
            r_burst_cnt  <= '0;
            r_wait_cnt   <= '0;
            r_ack        <= '0;
            r_err        <= '0;
            r_rdata      <= '0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rd_en      <= 1'b0;
            r_wr_en      <= 1'b0;
        end else begin
            // Strobes and acks are single-cycle pulses
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_ack   <= '0;
            r_err   <= '0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_win_valid) begin
                        r_id     <= w_win_id;
                        r_rr_ptr <= w_win_id;
                        r_addr   <= w_win_addr;
                        r_wdata  <= w_win_data;
                        r_rd_en  <= ~w_win_we;
                        r_wr_en  <= w_win_we;
                        // A fresh (non-lock) grant starts a new burst
                        if (!w_lock_hit) begin
                            r_lock_valid <= 1'b0;
                            r_burst_cnt  <= '0;
                        end
                    end
                end
                S_ISSUE: begin
                    r_wait_cnt <= '0;
                end
                S_WAIT: begin
                    if (device_ready) begin
                        r_rdata <= device_data_in;
                        r_ack   <= w_id_onehot;
                    end else if (w_timeout) begin
                        r_rdata <= '1;
                        r_ack   <= w_id_onehot;
                        r_err   <= w_id_onehot;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + c_WC_W'(1);
                    end
                end
                S_RESP: begin
                    // A timed-out transaction never extends a burst
                    if (core_lock[r_id] && !(|r_err) && (r_burst_cnt < c_BURST_LAST)) begin
                        r_lock_valid <= 1'b1;
                        r_burst_cnt  <= r_burst_cnt + c_BC_W'(1);
                    end else begin
                        r_lock_valid <= 1'b0;
                        r_burst_cnt  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign core_ack        = r_ack;
    assign core_err        = r_err;
    assign core_rdata      = r_rdata;
    assign device_addr     = r_addr;
    assign device_data_out = r_wdata;
    assign device_read_en  = r_rd_en;
    assign device_write_en = r_wr_en;
    assign device_core_id  = r_id;
    assign busy            = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_core_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_core_mem_arbiter
//  Description : Directed self-checking bench for core_mem_arbiter
//                (round-robin/timeout instance plus fixed-priority/no-timeout
//                instance).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_core_mem_arbiter;

    localparam int N  = 16;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Round-robin instance signals
    logic [N-1:0]    req = '0, we = '0, lock = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]    ack, err;
    logic [DW-1:0]   rdata, dev_dout;
    logic [AW-1:0]   dev_addr;
    logic            rd_en, wr_en, busy;
    logic [IW-1:0]   dev_id;
    logic            dev_rdy = 1'b0;
    logic [DW-1:0]   m_data = '0;
    int              m_delay = 1;

    // Fixed-priority instance signals
    logic [N-1:0]    f_req = '0, f_we = '0, f_lock = '0;
    logic [N*AW-1:0] f_addr = '0;
    logic [N*DW-1:0] f_wdata = '0;
    logic [N-1:0]    f_ack, f_err;
    logic [DW-1:0]   f_rdata, f_dout;
    logic [AW-1:0]   f_daddr;
    logic            f_rd, f_wr, f_busy;
    logic [IW-1:0]   f_id;
    logic            f_rdy = 1'b0;
    logic            f_force = 1'b0;
    logic [DW-1:0]   f_data = 32'h1234_5678;
    int              f_delay = 1;

    core_mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(0),
                       .MAX_BURST(4), .TIMEOUT_CYCLES(8)) u_rr (
        .clk(clk), .reset(reset), .core_req(req), .core_we(we), .core_lock(lock),
        .core_addr(addr), .core_wdata(wdata), .core_ack(ack), .core_err(err),
        .core_rdata(rdata), .device_addr(dev_addr), .device_read_en(rd_en),
        .device_write_en(wr_en), .device_data_out(dev_dout), .device_data_in(m_data),
        .device_ready(dev_rdy), .device_core_id(dev_id), .busy(busy));

    core_mem_arbiter #(.NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(1),
                       .MAX_BURST(4), .TIMEOUT_CYCLES(0)) u_fp (
        .clk(clk), .reset(reset), .core_req(f_req), .core_we(f_we), .core_lock(f_lock),
        .core_addr(f_addr), .core_wdata(f_wdata), .core_ack(f_ack), .core_err(f_err),
        .core_rdata(f_rdata), .device_addr(f_daddr), .device_read_en(f_rd),
        .device_write_en(f_wr), .device_data_out(f_dout), .device_data_in(f_data),
        .device_ready(f_rdy), .device_core_id(f_id), .busy(f_busy));

    // Device model for u_rr: ready m_delay cycles after the strobe cycle (0 = never)
    int m_left = 0;
    bit m_pend = 1'b0;
    always begin
        @(posedge clk); #2;
        dev_rdy = 1'b0;
        if (reset) m_pend = 1'b0;
        else begin
            if (m_pend) begin
                m_left--;
                if (m_left == 0) begin dev_rdy = 1'b1; m_pend = 1'b0; end
            end
            if ((rd_en || wr_en) && m_delay > 0) begin m_pend = 1'b1; m_left = m_delay; end
        end
    end

    // Device model for u_fp, with a manual ready override
    int f_left = 0;
    bit f_pend = 1'b0;
    always begin
        @(posedge clk); #2;
        f_rdy = f_force;
        if (reset) f_pend = 1'b0;
        else begin
            if (f_pend) begin
                f_left--;
                if (f_left == 0) begin f_rdy = 1'b1; f_pend = 1'b0; end
            end
            if ((f_rd || f_wr) && f_delay > 0) begin f_pend = 1'b1; f_left = f_delay; end
        end
    end

    int n_vec  = 0;
    int n_miss = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic set_core(input int c, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        we[c]              = w;
        addr[c*AW +: AW]   = a;
        wdata[c*DW +: DW]  = d;
    endtask

    task automatic wait_strobe(input bit fp, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            seen = fp ? (f_rd || f_wr) : (rd_en || wr_en);
        end
        check_eq({tag, "_strobe_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic wait_ack(input bit fp, input string tag, output int cyc);
        bit seen = 1'b0;
        cyc = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            cyc++;
            seen = fp ? (f_ack != '0) : (ack != '0);
        end
        check_eq({tag, "_ack_seen"}, 64'(seen), 64'd1);
    endtask

    int rr_exp[6] = '{0, 1, 5, 0, 1, 5};
    int bl_exp[4] = '{2, 2, 2, 7};
    int cyc;
    int nack;

    initial begin
        repeat (3) tick();
        // Reset state
        check_eq("rst_busy",  64'(busy),     64'd0);
        check_eq("rst_ack",   64'(ack),      64'd0);
        check_eq("rst_err",   64'(err),      64'd0);
        check_eq("rst_rd",    64'(rd_en),    64'd0);
        check_eq("rst_wr",    64'(wr_en),    64'd0);
        check_eq("rst_addr",  64'(dev_addr), 64'd0);
        check_eq("rst_id",    64'(dev_id),   64'd0);
        check_eq("rst_rdata", 64'(rdata),    64'd0);
        check_eq("rst_fbusy", 64'(f_busy),   64'd0);
        reset = 1'b0;
        tick();

        // Round-robin: cores 0, 1, 5 requesting continuously
        m_delay = 1;
        set_core(0, 1'b0, 32'h1000, '0);
        set_core(1, 1'b0, 32'h1001, '0);
        set_core(5, 1'b0, 32'h1005, '0);
        req[0] = 1'b1; req[1] = 1'b1; req[5] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wait_strobe(1'b0, $sformatf("rr%0d", k));
            check_eq($sformatf("rr%0d_id", k),   64'(dev_id),   64'(rr_exp[k]));
            check_eq($sformatf("rr%0d_addr", k), 64'(dev_addr), 64'(32'h1000 + rr_exp[k]));
            wait_ack(1'b0, $sformatf("rr%0d", k), cyc);
            check_eq($sformatf("rr%0d_ack", k),  64'(ack),      64'(16'h1 << rr_exp[k]));
        end
        req = '0;
        tick();
        check_eq("rr_idle", 64'(busy), 64'd0);

        // Fixed priority: lowest index keeps winning
        f_delay = 1;
        f_req[0] = 1'b1; f_req[1] = 1'b1; f_req[5] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_strobe(1'b1, $sformatf("fp%0d", k));
            check_eq($sformatf("fp%0d_id", k), 64'(f_id), 64'd0);
            wait_ack(1'b1, $sformatf("fp%0d", k), cyc);
            check_eq($sformatf("fp%0d_ack", k), 64'(f_ack), 64'h1);
        end
        f_req = '0;
        tick();

        // No timeout configured: wait indefinitely, then complete normally
        f_delay = 0;
        f_req[5] = 1'b1;
        wait_strobe(1'b1, "fto");
        nack = 0;
        repeat (40) begin
            tick();
            if (f_ack != '0) nack++;
        end
        check_eq("fto_noack", 64'(nack),   64'd0);
        check_eq("fto_busy",  64'(f_busy), 64'd1);
        f_force = 1'b1;
        tick();
        f_force = 1'b0;
        check_eq("fto_ack",   64'(f_ack),   64'h0020);
        check_eq("fto_err",   64'(f_err),   64'h0);
        check_eq("fto_rdata", 64'(f_rdata), 64'h1234_5678);
        f_req = '0;
        tick();

        // Single read by core 3, ready two cycles after the strobe
        m_delay = 2;
        m_data  = 32'hCAFE_F00D;
        set_core(3, 1'b0, 32'h100, '0);
        req[3] = 1'b1;
        tick();
        check_eq("rd_rd",   64'(rd_en),    64'd1);
        check_eq("rd_wr",   64'(wr_en),    64'd0);
        check_eq("rd_addr", 64'(dev_addr), 64'h100);
        check_eq("rd_id",   64'(dev_id),   64'd3);
        check_eq("rd_busy", 64'(busy),     64'd1);
        wait_ack(1'b0, "rd", cyc);
        check_eq("rd_lat",   64'(cyc),   64'd3);
        check_eq("rd_ack",   64'(ack),   64'h0008);
        check_eq("rd_err",   64'(err),   64'h0);
        check_eq("rd_rdata", 64'(rdata), 64'hCAFE_F00D);
        req = '0;
        tick();
        check_eq("rd_idle", 64'(busy), 64'd0);
        check_eq("rd_hold", 64'(rdata), 64'hCAFE_F00D);

        // Burst lock: core 2 locks, core 7 joins; expect 2,2,2,2,7
        m_delay = 1;
        set_core(2, 1'b0, 32'h200, '0);
        set_core(7, 1'b0, 32'h700, '0);
        req[2] = 1'b1; lock[2] = 1'b1;
        tick();
        check_eq("bl0_id", 64'(dev_id), 64'd2);
        req[7] = 1'b1;
        wait_ack(1'b0, "bl0", cyc);
        for (int k = 0; k < 4; k++) begin
            wait_strobe(1'b0, $sformatf("bl%0d", k + 1));
            check_eq($sformatf("bl%0d_id", k + 1), 64'(dev_id), 64'(bl_exp[k]));
            wait_ack(1'b0, $sformatf("bl%0d", k + 1), cyc);
        end
        req = '0; lock = '0;
        tick();

        // Write by core 15
        set_core(15, 1'b1, 32'h40, 32'hA5A5_A5A5);
        req[15] = 1'b1;
        tick();
        check_eq("wr_wr",   64'(wr_en),    64'd1);
        check_eq("wr_rd",   64'(rd_en),    64'd0);
        check_eq("wr_data", 64'(dev_dout), 64'hA5A5_A5A5);
        check_eq("wr_addr", 64'(dev_addr), 64'h40);
        check_eq("wr_id",   64'(dev_id),   64'd15);
        tick();
        check_eq("wr_pulse", 64'(wr_en), 64'd0);
        wait_ack(1'b0, "wr", cyc);
        check_eq("wr_ack", 64'(ack), 64'h8000);
        req = '0; we = '0;
        tick();

        // Timeout on core 4 (with lock), then core 6 must win next
        m_delay = 0;
        set_core(4, 1'b0, 32'h400, '0);
        req[4] = 1'b1; lock[4] = 1'b1;
        tick();
        check_eq("to_id", 64'(dev_id), 64'd4);
        wait_ack(1'b0, "to", cyc);
        check_eq("to_lat",   64'(cyc),   64'd9);
        check_eq("to_ack",   64'(ack),   64'h0010);
        check_eq("to_err",   64'(err),   64'h0010);
        check_eq("to_rdata", 64'(rdata), 64'hFFFF_FFFF);
        m_delay = 1;
        set_core(6, 1'b0, 32'h600, '0);
        req[6] = 1'b1;
        wait_strobe(1'b0, "to_next");
        check_eq("to_next_id", 64'(dev_id), 64'd6);
        wait_ack(1'b0, "to_next", cyc);
        check_eq("to_next_ack", 64'(ack), 64'h0040);
        req = '0; lock = '0;
        tick();

        // Reset during WAIT drops the transaction; core 9 is re-granted
        m_delay = 0;
        set_core(9, 1'b0, 32'h900, '0);
        req[9] = 1'b1;
        tick();
        check_eq("rw_rd", 64'(rd_en), 64'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_delay = 1;
        check_eq("rw_busy", 64'(busy),     64'd0);
        check_eq("rw_ack",  64'(ack),      64'd0);
        check_eq("rw_err",  64'(err),      64'd0);
        check_eq("rw_rd0",  64'(rd_en),    64'd0);
        check_eq("rw_wr0",  64'(wr_en),    64'd0);
        check_eq("rw_addr", 64'(dev_addr), 64'd0);
        tick();
        check_eq("rw_regrant_rd", 64'(rd_en),  64'd1);
        check_eq("rw_regrant_id", 64'(dev_id), 64'd9);
        wait_ack(1'b0, "rw", cyc);
        check_eq("rw_ack9", 64'(ack), 64'h0200);
        req = '0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
